// File: rtl/dfr_batch_controller_if.sv
// Handshake and configuration bundle between the DFR batch sequencer, the register
// file and the reservoir / matrix-multiply engines.
interface dfr_batch_controller_if #(
  parameter int INIT_CNT_WIDTH   = 16,
  parameter int SAMPLE_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH    = 16,
  parameter int BATCH_CNT_WIDTH  = 8
);
  logic                        start;
  logic                        abort;
  logic                        cfg_continuous;
  logic [INIT_CNT_WIDTH-1:0]   cfg_num_init;
  logic [SAMPLE_CNT_WIDTH-1:0] cfg_num_samples;
  logic [TIMEOUT_WIDTH-1:0]    cfg_timeout;
  logic                        reservoir_valid;
  logic                        reservoir_filled;
  logic                        matrix_multiply_busy;

  logic                        busy;
  logic                        reservoir_rst;
  logic                        reservoir_en;
  logic                        reservoir_history_en;
  logic                        reservoir_history_rst;
  logic                        matrix_multiply_rst;
  logic                        matrix_multiply_start;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_idx;
  logic [BATCH_CNT_WIDTH-1:0]  batch_count;
  logic                        dfr_done;
  logic                        timeout_err;

  // The sequencer drives the engines, so it takes the master side.
  modport master (
    input  start, abort, cfg_continuous, cfg_num_init, cfg_num_samples, cfg_timeout,
    input  reservoir_valid, reservoir_filled, matrix_multiply_busy,
    output busy, reservoir_rst, reservoir_en, reservoir_history_en, reservoir_history_rst,
    output matrix_multiply_rst, matrix_multiply_start, sample_idx, batch_count,
    output dfr_done, timeout_err
  );

  modport slave (
    output start, abort, cfg_continuous, cfg_num_init, cfg_num_samples, cfg_timeout,
    output reservoir_valid, reservoir_filled, matrix_multiply_busy,
    input  busy, reservoir_rst, reservoir_en, reservoir_history_en, reservoir_history_rst,
    input  matrix_multiply_rst, matrix_multiply_start, sample_idx, batch_count,
    input  dfr_done, timeout_err
  );
endinterface

// File: rtl/dfr_batch_controller.sv
// Batch sequencer for the hybrid DFR core: warm-up and run sampling of the reservoir,
// then one matrix-multiply launch, with per-wait watchdog, abort and back-to-back mode.
//
// state     | meaning
// IDLE      | waiting for start
// CLEAR     | clear reservoir, history and matrix multiply; zero sample counters
// INIT_REQ  | request one warm-up sample
// INIT_WAIT | wait for warm-up sample
// RUN_REQ   | request one run sample
// RUN_WAIT  | wait for run sample, capture it into history
// MM_START  | launch matrix multiply
// MM_WAIT   | wait for matrix multiply busy to rise and then fall
// DONE      | batch complete; count it, loop or return to IDLE
// ABORT     | abort / watchdog cleanup, then IDLE
module dfr_batch_controller #(
  parameter int INIT_CNT_WIDTH   = 16,
  parameter int SAMPLE_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH    = 16,
  parameter int BATCH_CNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  dfr_batch_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_INIT_REQ,
    S_INIT_WAIT,
    S_RUN_REQ,
    S_RUN_WAIT,
    S_MM_START,
    S_MM_WAIT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t                      state;
  state_t                      state_nxt;

  logic [INIT_CNT_WIDTH-1:0]   num_init_q;
  logic [SAMPLE_CNT_WIDTH-1:0] num_samples_q;
  logic [TIMEOUT_WIDTH-1:0]    timeout_q;
  logic                        continuous_q;

  logic [INIT_CNT_WIDTH-1:0]   init_cnt;
  logic [INIT_CNT_WIDTH-1:0]   init_cnt_inc;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_idx_q;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_idx_inc;
  logic [TIMEOUT_WIDTH-1:0]    wd_cnt;
  logic [BATCH_CNT_WIDTH-1:0]  batch_cnt_q;
  logic                        seen_busy;
  logic                        timeout_err_q;
  logic                        zero_done_q;

  logic                        idle_start;
  logic                        in_wait;
  logic                        wd_load;
  logic                        wd_expired;
  logic                        wd_fire;
  logic                        sample_ok;
  logic                        mm_finished;

  assign init_cnt_inc   = init_cnt + 1'b1;
  assign sample_idx_inc = sample_idx_q + 1'b1;

  assign idle_start  = (state == S_IDLE) && bus.start;
  assign in_wait     = (state == S_INIT_WAIT) || (state == S_RUN_WAIT) || (state == S_MM_WAIT);
  assign wd_load     = (state == S_INIT_REQ) || (state == S_RUN_REQ) || (state == S_MM_START);
  assign sample_ok   = bus.reservoir_valid && !bus.abort;
  assign mm_finished = seen_busy && !bus.matrix_multiply_busy;

  // Watchdog is a down-counter loaded with timeout-1 on the request cycle, so it
  // reaches zero after exactly `timeout` cycles in the wait state.
  assign wd_expired = (timeout_q != '0) && (wd_cnt == '0);
  assign wd_fire    = in_wait && (state_nxt == S_ABORT) && !bus.abort;

  always_comb begin
    state_nxt = state;
    if ((state != S_IDLE) && bus.abort) begin
      state_nxt = S_ABORT;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && (bus.cfg_num_samples != '0)) state_nxt = S_CLEAR;
        end
        S_CLEAR: begin
          state_nxt = (num_init_q != '0) ? S_INIT_REQ : S_RUN_REQ;
        end
        S_INIT_REQ: state_nxt = S_INIT_WAIT;
        S_INIT_WAIT: begin
          if (bus.reservoir_valid) begin
            state_nxt = (init_cnt_inc == num_init_q) ? S_RUN_REQ : S_INIT_REQ;
          end else if (wd_expired) begin
            state_nxt = S_ABORT;
          end
        end
        S_RUN_REQ: state_nxt = S_RUN_WAIT;
        S_RUN_WAIT: begin
          if (bus.reservoir_valid) begin
            state_nxt = (sample_idx_inc == num_samples_q) ? S_MM_START : S_RUN_REQ;
          end else if (wd_expired) begin
            state_nxt = S_ABORT;
          end
        end
        S_MM_START: state_nxt = S_MM_WAIT;
        S_MM_WAIT: begin
          if (mm_finished) begin
            state_nxt = S_DONE;
          end else if (wd_expired) begin
            state_nxt = S_ABORT;
          end
        end
        S_DONE:  state_nxt = continuous_q ? S_CLEAR : S_IDLE;
        S_ABORT: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      num_init_q    <= '0;
      num_samples_q <= '0;
      timeout_q     <= '0;
      continuous_q  <= 1'b0;
      init_cnt      <= '0;
      sample_idx_q  <= '0;
      wd_cnt        <= '0;
      batch_cnt_q   <= '0;
      seen_busy     <= 1'b0;
      timeout_err_q <= 1'b0;
      zero_done_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      zero_done_q <= idle_start && (bus.cfg_num_samples == '0);

      // Configuration is sampled on every entry to CLEAR, including continuous loops.
      if (state_nxt == S_CLEAR) begin
        num_init_q    <= bus.cfg_num_init;
        num_samples_q <= bus.cfg_num_samples;
        timeout_q     <= bus.cfg_timeout;
        continuous_q  <= bus.cfg_continuous;
      end

      if (idle_start) begin
        timeout_err_q <= 1'b0;
      end else if (wd_fire) begin
        timeout_err_q <= 1'b1;
      end

      if (state == S_CLEAR) begin
        init_cnt     <= '0;
        sample_idx_q <= '0;
      end
      if ((state == S_INIT_WAIT) && sample_ok) init_cnt <= init_cnt_inc;
      if ((state == S_RUN_WAIT) && sample_ok) sample_idx_q <= sample_idx_inc;

      if (wd_load) begin
        wd_cnt <= timeout_q - 1'b1;
      end else if (in_wait && (wd_cnt != '0)) begin
        wd_cnt <= wd_cnt - 1'b1;
      end

      if (state == S_MM_START) begin
        seen_busy <= 1'b0;
      end else if ((state == S_MM_WAIT) && bus.matrix_multiply_busy) begin
        seen_busy <= 1'b1;
      end

      if (state == S_DONE) batch_cnt_q <= batch_cnt_q + 1'b1;
    end
  end

  assign bus.busy                  = (state != S_IDLE);
  assign bus.reservoir_rst         = (state == S_CLEAR) || (state == S_ABORT);
  assign bus.matrix_multiply_rst   = (state == S_CLEAR) || (state == S_ABORT);
  assign bus.reservoir_history_rst = (state == S_CLEAR);
  assign bus.reservoir_en          = (state == S_INIT_REQ) || (state == S_RUN_REQ);
  assign bus.matrix_multiply_start = (state == S_MM_START);
  assign bus.reservoir_history_en  = (state == S_RUN_WAIT) && bus.reservoir_valid &&
                                     bus.reservoir_filled;
  assign bus.dfr_done              = (state == S_DONE) || zero_done_q;
  assign bus.sample_idx            = sample_idx_q;
  assign bus.batch_count           = batch_cnt_q;
  assign bus.timeout_err           = timeout_err_q;

endmodule

// File: tb/tb_dfr_batch_controller.sv
// Directed bench for dfr_batch_controller with simple reservoir and matrix-multiply
// responders; expected values are hand-derived from the cycle-level behaviour.
module tb_dfr_batch_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dfr_batch_controller_if bus();

  dfr_batch_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reservoir responder: one valid pulse res_delay+1 cycles after each en.
  logic auto_valid = 1'b0;
  logic man_valid  = 1'b0;
  int   res_delay  = 4;
  bit   res_enable = 1'b1;
  assign bus.reservoir_valid = auto_valid | man_valid;

  initial begin
    int res_cnt;
    res_cnt = -1;
    forever begin
      @(posedge clk); #1;
      auto_valid = 1'b0;
      if (res_cnt == 0) begin
        auto_valid = res_enable;
        res_cnt = -1;
      end else if (res_cnt > 0) begin
        res_cnt--;
      end
      if (bus.reservoir_en) res_cnt = res_delay;
    end
  end

  // Matrix-multiply responder: busy after mm_lat cycles, held mm_hold cycles.
  int mm_lat  = 1;
  int mm_hold = 2;
  initial begin
    int lat_cnt;
    int hold_cnt;
    lat_cnt = 0;
    hold_cnt = 0;
    bus.matrix_multiply_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_cnt > 0) begin
        bus.matrix_multiply_busy = 1'b1;
        hold_cnt--;
      end else begin
        bus.matrix_multiply_busy = 1'b0;
      end
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) hold_cnt = mm_hold;
      end
      if (bus.matrix_multiply_start) lat_cnt = mm_lat;
    end
  end

  int   n_en = 0, n_mm = 0, n_done = 0, n_hist = 0, n_hist_valid = 0, n_rrst = 0;
  int   to_rise_cyc = -1;
  logic to_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.reservoir_en) n_en++;
    if (bus.matrix_multiply_start) n_mm++;
    if (bus.dfr_done) n_done++;
    if (bus.reservoir_history_en) n_hist++;
    if (bus.reservoir_history_en && bus.reservoir_valid) n_hist_valid++;
    if (bus.reservoir_rst) n_rrst++;
    if (bus.timeout_err && !to_prev) to_rise_cyc = cyc;
    to_prev = bus.timeout_err;
  end

  task automatic kick(input int ni, input int ns, input int to, input bit cont, output int t0);
    @(posedge clk); #1;
    bus.cfg_num_init    = ni[15:0];
    bus.cfg_num_samples = ns[15:0];
    bus.cfg_timeout     = to[15:0];
    bus.cfg_continuous  = cont;
    bus.start           = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < max);
    #1;
    check_val(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  // sel: 0 reservoir_en, 1 matrix_multiply_start, 2 dfr_done
  task automatic wait_pulse(input int sel, input int max, output int at);
    at = -1;
    for (int i = 0; i < max && at < 0; i++) begin
      @(negedge clk);
      if ((sel == 0 && bus.reservoir_en) || (sel == 1 && bus.matrix_multiply_start) ||
          (sel == 2 && bus.dfr_done))
        at = cyc;
    end
  endtask

  initial begin
    int t0, at, mm_at, d_at, seen, n;
    int b_en, b_mm, b_done, b_hist, b_hv, b_rrst;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_continuous = 1'b0;
    bus.cfg_num_init = '0;
    bus.cfg_num_samples = '0;
    bus.cfg_timeout = '0;
    bus.reservoir_filled = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, bus.busy}, 0);
    check_val("rst_sample_idx", {16'd0, bus.sample_idx}, 0);
    check_val("rst_batch_count", {24'd0, bus.batch_count}, 0);
    check_val("rst_timeout_err", {31'd0, bus.timeout_err}, 0);
    check_val("rst_dfr_done", {31'd0, bus.dfr_done}, 0);
    rst = 1'b0;

    // Basic batch: init=2, samples=3; mid-batch cfg changes must be ignored
    b_en = n_en; b_mm = n_mm; b_done = n_done; b_hist = n_hist; b_rrst = n_rrst;
    kick(2, 3, 0, 1'b0, t0);
    bus.cfg_num_samples = 16'd7;
    bus.cfg_num_init = 16'd5;
    wait_pulse(0, 20, at);
    check_val("t1_first_en_latency", at - t0, 2);
    wait_idle(300, "t1_idle");
    check_val("t1_en_count", n_en - b_en, 5);
    check_val("t1_mm_start_count", n_mm - b_mm, 1);
    check_val("t1_done_count", n_done - b_done, 1);
    check_val("t1_hist_count", n_hist - b_hist, 3);
    check_val("t1_rrst_count", n_rrst - b_rrst, 1);
    check_val("t1_sample_idx", {16'd0, bus.sample_idx}, 3);
    check_val("t1_batch_count", {24'd0, bus.batch_count}, 1);

    // init=0, samples=1, reservoir not filled
    bus.reservoir_filled = 1'b0;
    b_en = n_en; b_hist = n_hist; b_done = n_done;
    kick(0, 1, 0, 1'b0, t0);
    wait_idle(100, "t2a_idle");
    check_val("t2a_en_count", n_en - b_en, 1);
    check_val("t2a_hist_count", n_hist - b_hist, 0);
    check_val("t2a_done_count", n_done - b_done, 1);
    check_val("t2a_batch_count", {24'd0, bus.batch_count}, 2);

    // Same with reservoir filled: one history capture coincident with valid
    bus.reservoir_filled = 1'b1;
    b_hist = n_hist; b_hv = n_hist_valid;
    kick(0, 1, 0, 1'b0, t0);
    wait_idle(100, "t2b_idle");
    check_val("t2b_hist_count", n_hist - b_hist, 1);
    check_val("t2b_hist_with_valid", n_hist_valid - b_hv, 1);
    check_val("t2b_batch_count", {24'd0, bus.batch_count}, 3);

    // Zero samples: dfr_done pulses next cycle, no engine activity
    b_en = n_en;
    kick(0, 0, 0, 1'b0, t0);
    check_val("tz_done_pulse", {31'd0, bus.dfr_done}, 1);
    check_val("tz_busy", {31'd0, bus.busy}, 0);
    @(posedge clk); #1;
    check_val("tz_done_cleared", {31'd0, bus.dfr_done}, 0);
    check_val("tz_en_count", n_en - b_en, 0);
    check_val("tz_batch_count", {24'd0, bus.batch_count}, 3);

    // Watchdog: timeout=10 with the reservoir silent
    res_enable = 1'b0;
    b_done = n_done; b_rrst = n_rrst;
    kick(2, 3, 10, 1'b0, t0);
    wait_idle(100, "t3_idle");
    check_val("t3_timeout_cycle", to_rise_cyc - t0, 13);
    check_val("t3_timeout_err", {31'd0, bus.timeout_err}, 1);
    check_val("t3_rrst_count", n_rrst - b_rrst, 2);
    check_val("t3_done_count", n_done - b_done, 0);
    check_val("t3_batch_count", {24'd0, bus.batch_count}, 3);
    res_enable = 1'b1;
    kick(0, 1, 0, 1'b0, t0);
    check_val("t3_err_cleared", {31'd0, bus.timeout_err}, 0);
    wait_idle(100, "t3_recover_idle");
    check_val("t3_recover_batch", {24'd0, bus.batch_count}, 4);

    // Continuous mode: drop cfg_continuous during batch 3, expect 4 batches total
    b_en = n_en; b_mm = n_mm; b_done = n_done;
    kick(0, 2, 0, 1'b1, t0);
    seen = 0; n = 0;
    while (seen < 2 && n < 400) begin
      @(negedge clk);
      if (bus.dfr_done) seen++;
      n++;
    end
    @(posedge clk); #1;
    bus.cfg_continuous = 1'b0;
    wait_idle(600, "t4_idle");
    check_val("t4_done_count", n_done - b_done, 4);
    check_val("t4_mm_count", n_mm - b_mm, 4);
    check_val("t4_en_count", n_en - b_en, 8);
    check_val("t4_batch_count", {24'd0, bus.batch_count}, 8);

    // Abort in RUN_WAIT in the same cycle as reservoir_valid
    res_enable = 1'b0;
    b_done = n_done;
    kick(0, 3, 0, 1'b0, t0);
    wait_pulse(0, 20, at);
    @(posedge clk); #1;
    man_valid = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    man_valid = 1'b0;
    bus.abort = 1'b0;
    check_val("t5_abort_busy", {31'd0, bus.busy}, 1);
    check_val("t5_abort_rrst", {31'd0, bus.reservoir_rst}, 1);
    check_val("t5_sample_idx", {16'd0, bus.sample_idx}, 0);
    @(posedge clk); #1;
    check_val("t5_idle_after", {31'd0, bus.busy}, 0);
    check_val("t5_done_count", n_done - b_done, 0);
    check_val("t5_batch_count", {24'd0, bus.batch_count}, 8);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_val("t5_idle_abort_busy", {31'd0, bus.busy}, 0);
    check_val("t5_idle_abort_rrst", {31'd0, bus.reservoir_rst}, 0);
    res_enable = 1'b1;

    // Synchronous reset in the middle of MM_WAIT
    res_delay = 1; mm_lat = 2; mm_hold = 20;
    kick(0, 1, 0, 1'b0, t0);
    wait_pulse(1, 60, at);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("t6_busy_before", {31'd0, bus.busy}, 1);
    check_val("t6_idx_before", {16'd0, bus.sample_idx}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("t6_outputs_zero",
              {23'd0, bus.busy, bus.reservoir_rst, bus.reservoir_en, bus.reservoir_history_en,
               bus.reservoir_history_rst, bus.matrix_multiply_rst, bus.matrix_multiply_start,
               bus.dfr_done, bus.timeout_err}, 0);
    check_val("t6_batch_zero", {24'd0, bus.batch_count}, 0);
    check_val("t6_idx_zero", {16'd0, bus.sample_idx}, 0);
    rst = 1'b0;
    repeat (30) @(posedge clk);

    // Matrix multiply start latency: DONE only after busy has risen and fallen
    res_delay = 2; mm_lat = 3; mm_hold = 5;
    kick(0, 1, 0, 1'b0, t0);
    wait_pulse(1, 60, mm_at);
    wait_pulse(2, 60, d_at);
    check_val("t7_mm_to_done", d_at - mm_at, 10);
    wait_idle(20, "t7_idle");
    check_val("t7_batch_count", {24'd0, bus.batch_count}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1);
  end
endmodule
